// File: rtl/rambus_pkg.sv
// rambus_pkg: shared MMIO offsets, STATUS bit positions and bus target encoding for rambus
package rambus_pkg;
    localparam logic [1:0] TXDATA_OFS = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] CNTLO_OFS  = 2'd2;
    localparam logic [1:0] CNTHI_OFS  = 2'd3;
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;
    typedef enum logic [1:0] {TGT_RAM, TGT_MMIO, TGT_NONE} bus_target_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO without fall-through; a push while full is accepted only alongside a pop
//   clk/rst: clock, sync active-high reset | push/din: write side | pop/dout: head side
//   full/empty/count: occupancy flags and entry count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem_q[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/rambus.sv
// rambus: decodes processor RAM-bus accesses to byte-strobed data RAM, MMIO (TX FIFO + cycle counter) or unmapped space
//   clk/rst: clock, sync active-high reset
//   bus_addr/bus_re/bus_we/bus_wstrb/bus_wdata: processor access | bus_rdata: combinational read data
//   tx_data/tx_valid/tx_ready: TX FIFO drain port
module rambus
    import rambus_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic        bus_re,
    input  logic        bus_we,
    input  logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [31:0] mem [MEM_WORDS];
    logic [63:0] counter;
    logic [31:0] shadow_hi;
    logic        overflow;
    bus_target_t tgt;
    logic [AW-1:0] ram_idx;
    logic [1:0]  ofs;
    logic        mmio_wr, mmio_rd, push, pop, full, empty, ovf_clr;
    logic [CW-1:0] count;
    logic [3:0]  occ;
    logic [31:0] status, mmio_rdata;
    always_comb begin
        tgt = bus_addr < 32'(MEM_WORDS * 4) ? TGT_RAM :
              bus_addr[31:4] == MMIO_BASE[31:4] ? TGT_MMIO : TGT_NONE;
    end
    assign ram_idx  = bus_addr[AW+1:2];
    assign ofs      = bus_addr[3:2];
    // MMIO side effects are masked during reset; RAM writes are not
    assign mmio_wr  = bus_we & (tgt == TGT_MMIO) & ~rst;
    assign mmio_rd  = bus_re & (tgt == TGT_MMIO) & ~rst;
    assign push     = mmio_wr & (ofs == TXDATA_OFS) & bus_wstrb[0];
    assign ovf_clr  = mmio_wr & (ofs == STATUS_OFS) & bus_wstrb[0] & bus_wdata[ST_OVF];
    assign tx_valid = ~empty;
    assign pop      = tx_valid & tx_ready;
    assign occ      = 32'(count) > 15 ? 4'hF : 4'(count);
    always_comb begin
        status                    = '0;
        status[ST_FULL]           = full;
        status[ST_EMPTY]          = empty;
        status[ST_OVF]            = overflow;
        status[ST_CNT_LSB +: 4]   = occ;
        mmio_rdata = ofs == STATUS_OFS ? status :
                     ofs == CNTLO_OFS  ? counter[31:0] :
                     ofs == CNTHI_OFS  ? shadow_hi : '0;
        bus_rdata  = !bus_re          ? '0 :
                     tgt == TGT_RAM   ? mem[ram_idx] :
                     tgt == TGT_MMIO  ? mmio_rdata : '0;
    end
    always_ff @(posedge clk) begin
        if (bus_we && tgt == TGT_RAM)
            for (int i = 0; i < 4; i++)
                if (bus_wstrb[i]) mem[ram_idx][8*i +: 8] <= bus_wdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= '0;
            shadow_hi <= '0;
            overflow  <= 1'b0;
        end else begin
            counter <= counter + 64'd1;
            if (mmio_rd && ofs == CNTLO_OFS) shadow_hi <= counter[63:32];
            // a dropped push outranks a same-cycle clear
            overflow <= (push & full & ~pop) | (overflow & ~ovf_clr);
        end
    end
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (bus_wdata[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_rambus.sv
// tb_rambus: directed self-checking bench for rambus
module tb_rambus;
    localparam logic [31:0] MB = 32'h1000_0000;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] bus_addr = '0;
    logic        bus_re = 0;
    logic        bus_we = 0;
    logic [3:0]  bus_wstrb = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 0;
    int errors = 0;
    int checks = 0;
    logic [31:0] r;

    rambus dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_re    (bus_re),
        .bus_we    (bus_we),
        .bus_wstrb (bus_wstrb),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus_addr = a; bus_wdata = d; bus_wstrb = s; bus_we = 1;
        tick();
        bus_we = 0; bus_wstrb = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a; bus_re = 1;
        #1 d = bus_rdata;
        tick();
        bus_re = 0;
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        rd(MB + 4, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", r); end
        rd(MB + 8, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL reset_cnt_lo: got %h expected 00000001", r); end
        rd(MB + 12, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_cnt_hi: got %h expected 00000000", r); end
    endtask

    task automatic test_ram_strobes();
        wr(32'h40, 32'hAABBCCDD, 4'b1111);
        wr(32'h40, 32'h0011_0000, 4'b0100);
        rd(32'h40, r);
        checks++; if (r !== 32'hAA11CCDD) begin errors++; $display("FAIL ram_strobe: got %h expected aa11ccdd", r); end
        rd(32'h43, r);
        checks++; if (r !== 32'hAA11CCDD) begin errors++; $display("FAIL ram_byte_offset: got %h expected aa11ccdd", r); end
        wr(32'h44, 32'h1234_5678, 4'b1001);
        rd(32'h44, r);
        checks++; if (r[31:24] !== 8'h12 || r[7:0] !== 8'h78) begin errors++; $display("FAIL ram_strobe_1001: got %h expected 12xxxx78", r); end
        bus_addr = 32'h40; bus_re = 0;
        #1 checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL re_low: got %h expected 00000000", bus_rdata); end
        bus_re = 1; bus_we = 1; bus_wdata = 32'h5566_7788; bus_wstrb = 4'hF;
        #1 checks++; if (bus_rdata !== 32'hAA11CCDD) begin errors++; $display("FAIL rw_same_cycle: got %h expected aa11ccdd", bus_rdata); end
        tick();
        bus_re = 0; bus_we = 0; bus_wstrb = '0;
        rd(32'h40, r);
        checks++; if (r !== 32'h55667788) begin errors++; $display("FAIL rw_commit: got %h expected 55667788", r); end
    endtask

    task automatic test_unmapped();
        wr(32'h0, 32'h1234_5678, 4'hF);
        rd(32'h2000_0000, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 00000000", r); end
        wr(32'h2000_0000, 32'hFFFF_FFFF, 4'hF);
        rd(32'h0, r);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL unmapped_write: got %h expected 12345678", r); end
        rd(MB, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 00000000", r); end
    endtask

    task automatic test_fifo_order();
        tx_ready = 0;
        bus_addr = MB; bus_wdata = 32'h41; bus_wstrb = 4'h1; bus_we = 1;
        #1 checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL no_fall_through: got %b expected 0", tx_valid); end
        tick();
        bus_we = 0; bus_wstrb = '0;
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL push_visible: got %b expected 1", tx_valid); end
        wr(MB, 32'h42, 4'h1);
        wr(MB, 32'h43, 4'h1);
        rd(MB + 4, r);
        checks++; if (r !== 32'h30) begin errors++; $display("FAIL fifo_status3: got %h expected 00000030", r); end
        tx_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin errors++; $display("FAIL fifo_order%0d: got v=%b d=%h expected v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_drained: got %b expected 0", tx_valid); end
        tx_ready = 0;
        rd(MB + 4, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL fifo_status_empty: got %h expected 00000002", r); end
    endtask

    task automatic test_overflow();
        tx_ready = 0;
        for (int i = 0; i < 9; i++) wr(MB, 32'(8'h10 + i), 4'h1);
        rd(MB + 4, r);
        checks++; if (r !== 32'h85) begin errors++; $display("FAIL ovf_status: got %h expected 00000085", r); end
        tx_ready = 1;
        wr(MB, 32'h20, 4'h1);
        tx_ready = 0;
        rd(MB + 4, r);
        checks++; if (r !== 32'h85) begin errors++; $display("FAIL full_push_pop: got %h expected 00000085", r); end
        checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL full_push_pop_head: got %h expected 11", tx_data); end
        wr(MB + 4, 32'h0, 4'h1);
        rd(MB + 4, r);
        checks++; if (r !== 32'h85) begin errors++; $display("FAIL ovf_no_clear: got %h expected 00000085", r); end
        wr(MB + 4, 32'h4, 4'h1);
        rd(MB + 4, r);
        checks++; if (r !== 32'h81) begin errors++; $display("FAIL ovf_clear: got %h expected 00000081", r); end
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_data !== (i == 7 ? 8'h20 : 8'(8'h11 + i))) begin errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, tx_data, (i == 7 ? 8'h20 : 8'(8'h11 + i))); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", tx_valid); end
        tx_ready = 0;
    endtask

    task automatic test_counter_snapshot();
        force dut.counter = 64'h0000_0001_FFFF_FFFF;
        #1 release dut.counter;
        rd(MB + 8, r);
        checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cnt_lo_snap: got %h expected ffffffff", r); end
        for (int i = 0; i < 5; i++) tick();
        rd(MB + 12, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL cnt_hi_shadow: got %h expected 00000001", r); end
        rd(MB + 8, r);
        checks++; if (r !== 32'h6) begin errors++; $display("FAIL cnt_lo_wrap: got %h expected 00000006", r); end
        rd(MB + 12, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL cnt_hi_new: got %h expected 00000002", r); end
    endtask

    task automatic test_reset_mid_drain();
        tx_ready = 0;
        for (int i = 0; i < 3; i++) wr(MB, 32'(8'h60 + i), 4'h1);
        tx_ready = 1;
        tick();
        rst = 1;
        wr(32'h80, 32'hCAFE_F00D, 4'hF);
        rst = 0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", tx_valid); end
        rd(MB + 4, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL rst_mid_status: got %h expected 00000002", r); end
        rd(MB + 8, r);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL rst_mid_cnt: got %h expected 00000001", r); end
        rd(32'h80, r);
        checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_ram_write: got %h expected cafef00d", r); end
        tx_ready = 0;
    endtask

    initial begin
        test_reset();
        test_ram_strobes();
        test_unmapped();
        test_fifo_order();
        test_overflow();
        test_counter_snapshot();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
